// File: rtl/npipe_sched_if.sv
// Handshake bundle linking NREQ requesters, the round-robin scheduler and the
// shared fixed-latency pipeline it feeds.
interface npipe_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [WIDTH-1:0]      pipe_in;
  logic                  pipe_in_valid;
  logic [WIDTH-1:0]      pipe_out;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic [NREQ-1:0]       rsp_ready;

  // Environment view: requesters plus the shared pipeline output.
  modport master (
    output req_valid, req_data, rsp_ready, pipe_out,
    input  req_ready, rsp_valid, rsp_data, pipe_in, pipe_in_valid
  );

  modport slave (
    input  req_valid, req_data, rsp_ready, pipe_out,
    output req_ready, rsp_valid, rsp_data, pipe_in, pipe_in_valid
  );
endinterface

// File: rtl/npipe_sched.sv
// Round-robin scheduler sharing one non-stallable DEPTH-cycle pipeline among NREQ
// requesters; a tag line tracks requester IDs and credits keep the response FIFO safe.
module npipe_sched #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int FDEPTH = 4,
  localparam int CW    = $clog2(FDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  npipe_sched_if.slave  bus,
  output logic [CW-1:0] outstanding
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;

  logic [IW-1:0]    last_q, last_d;
  logic [CW-1:0]    out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [DEPTH-1:0] tag_v_q, tag_v_d;
  logic [IW-1:0]    tag_id_q [DEPTH];
  logic [IW-1:0]    tag_id_d [DEPTH];
  logic [WIDTH-1:0] mem_data_q [FDEPTH];
  logic [IW-1:0]    mem_id_q [FDEPTH];

  logic          issue_s, pop_s, we_s, empty_s, full_s;
  logic [IW-1:0] gid_s, cand_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit-gated round-robin search starting just after the last granted requester.
  always_comb begin
    issue_s = 1'b0;
    gid_s   = last_q;
    cand_s  = last_q;
    if (rst && (out_q < CW'(FDEPTH))) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand_s  = IW'((int'(last_q) + k) % NREQ);
        gid_s   = (!issue_s && bus.req_valid[cand_s]) ? cand_s : gid_s;
        issue_s = issue_s | bus.req_valid[cand_s];
      end
    end else begin
      issue_s = 1'b0;
    end
  end

  // Grant, pipeline feed and FIFO head presentation.
  always_comb begin
    bus.req_ready     = issue_s ? (NREQ'(1) << gid_s) : '0;
    bus.pipe_in_valid = issue_s;
    bus.pipe_in       = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.pipe_in = (issue_s && (gid_s == IW'(i))) ? bus.req_data[i*WIDTH +: WIDTH] : bus.pipe_in;
    end
    empty_s       = (cnt_q == '0);
    full_s        = (cnt_q == CW'(FDEPTH));
    bus.rsp_valid = empty_s ? '0 : (NREQ'(1) << mem_id_q[rd_q]);
    bus.rsp_data  = empty_s ? '0 : mem_data_q[rd_q];
    pop_s         = |(bus.rsp_valid & bus.rsp_ready);
    we_s          = tag_v_q[DEPTH-1];
  end

  // Next state: credits, arbitration pointer, FIFO pointers and the unstalled tag line.
  always_comb begin
    out_d       = out_q + CW'(issue_s) - CW'(pop_s);
    cnt_d       = cnt_q + CW'(we_s) - CW'(pop_s);
    last_d      = issue_s ? gid_s : last_q;
    wr_d        = we_s ? next_ptr(wr_q) : wr_q;
    rd_d        = pop_s ? next_ptr(rd_q) : rd_q;
    tag_v_d     = '0;
    tag_v_d[0]  = issue_s;
    tag_id_d[0] = issue_s ? gid_s : '0;
    for (int i = 1; i < DEPTH; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
  end

  // Control state; clearing the tags drops any results still inside the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= IW'(NREQ - 1);
      out_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      tag_v_q <= '0;
      for (int i = 0; i < DEPTH; i++) tag_id_q[i] <= '0;
    end else begin
      last_q   <= last_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
    end
  end

  // FIFO storage has no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_data_q[wr_q] <= bus.pipe_out;
      mem_id_q[wr_q]   <= tag_id_q[DEPTH-1];
    end
  end

  assign outstanding = out_q;

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst) !(we_s && full_s));
endmodule

// File: tb/tb_npipe_sched.sv
// Directed bench for npipe_sched: a cycle model issues expectations into a scoreboard,
// a separate monitor checks every popped response, and directed checks pin hand values.
module tb_npipe_sched;
  localparam int NREQ = 4, WIDTH = 32, DEPTH = 4, FDEPTH = 4;
  localparam int CW = $clog2(FDEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] outstanding;

  npipe_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  npipe_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared pipeline: a pure DEPTH-cycle delay, never reset.
  logic [WIDTH-1:0] pl [DEPTH];
  always @(posedge clk) begin
    pl[0] <= bus.pipe_in;
    for (int k = 1; k < DEPTH; k++) pl[k] <= pl[k-1];
  end
  assign bus.pipe_out = pl[DEPTH-1];

  int               sb_id   [256];
  logic [WIDTH-1:0] sb_data [256];
  int wr_n = 0;
  int m_pass = 0, m_tot = 0, s_pass = 0, s_tot = 0, d_pass = 0, d_tot = 0;

  function automatic bit same(string nm, logic [63:0] got, logic [63:0] exp);
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic mchk(string nm, logic [63:0] got, logic [63:0] exp);
    m_tot++;
    m_pass += int'(same(nm, got, exp));
  endtask

  task automatic dchk(string nm, logic [63:0] got, logic [63:0] exp);
    d_tot++;
    d_pass += int'(same(nm, got, exp));
  endtask

  // Cycle model: predicts grant, credits and FIFO head; pushes each issue to the scoreboard.
  initial begin : model
    int mhead, mfcnt, mlast, g, c, eo;
    logic [DEPTH-1:0] mtag_v;
    logic [NREQ-1:0]  erv, err;
    logic [WIDTH-1:0] erd, epi;
    logic             mpop;
    mhead = 0; mfcnt = 0; mlast = NREQ - 1; mtag_v = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mhead = wr_n; mfcnt = 0; mtag_v = '0; mlast = NREQ - 1;
        mchk("rst_req_ready", bus.req_ready, 0);
        mchk("rst_pipe_in_valid", bus.pipe_in_valid, 0);
        mchk("rst_rsp_valid", bus.rsp_valid, 0);
        mchk("rst_outstanding", outstanding, 0);
      end else begin
        eo  = wr_n - mhead;
        erv = (mfcnt > 0) ? (NREQ'(1) << sb_id[mhead % 256]) : '0;
        erd = (mfcnt > 0) ? sb_data[mhead % 256] : '0;
        g = -1;
        if (eo < FDEPTH) begin
          for (int k = 1; k <= NREQ; k++) begin
            c = (mlast + k) % NREQ;
            if (g < 0 && bus.req_valid[c]) g = c;
          end
        end
        err = (g >= 0) ? (NREQ'(1) << g) : '0;
        epi = (g >= 0) ? bus.req_data[g*WIDTH +: WIDTH] : '0;
        mchk("req_ready", bus.req_ready, err);
        mchk("pipe_in_valid", bus.pipe_in_valid, (g >= 0) ? 1 : 0);
        mchk("pipe_in", bus.pipe_in, epi);
        mchk("rsp_valid", bus.rsp_valid, erv);
        mchk("rsp_data", bus.rsp_data, erd);
        mchk("outstanding", outstanding, eo);
        mpop = ((erv & bus.rsp_ready) != '0);
        if (g >= 0) begin
          sb_id[wr_n % 256]   = g;
          sb_data[wr_n % 256] = epi;
          wr_n++;
          mlast = g;
        end
        if (mpop) mhead++;
        mfcnt  = mfcnt + int'(mtag_v[DEPTH-1]) - int'(mpop);
        mtag_v = {mtag_v[DEPTH-2:0], (g >= 0)};
      end
    end
  end

  // Monitor: every DUT pop must match the oldest outstanding scoreboard entry.
  initial begin : monitor
    int rd;
    rd = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rd = wr_n;
      end else if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
        s_tot++;
        if (rd == wr_n) begin
          $display("FAIL sb_unexpected_pop: got rsp_valid %0h expected no response (t=%0t)", bus.rsp_valid, $time);
        end else begin
          s_pass += int'(same("sb_rsp_id", bus.rsp_valid, NREQ'(1) << sb_id[rd % 256]) &&
                         same("sb_rsp_data", bus.rsp_data, sb_data[rd % 256]));
          rd++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [NREQ-1:0] fair_tbl [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
                                     4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin : stim
    bus.req_valid = '0; bus.req_data = '0; bus.rsp_ready = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.req_valid = '1;
    #1;
    dchk("reset_req_ready", bus.req_ready, 0);
    dchk("reset_pipe_in", bus.pipe_in, 0);
    dchk("reset_rsp_data", bus.rsp_data, 0);
    dchk("reset_outstanding", outstanding, 0);
    bus.req_valid = '0;
    step();

    // Single request from requester 2.
    rst = 1'b1;
    bus.rsp_ready = '1;
    bus.req_data[2*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
    bus.req_valid = 4'b0100;
    #1;
    dchk("single_ready", bus.req_ready, 4'b0100);
    dchk("single_pipe_in_valid", bus.pipe_in_valid, 1);
    dchk("single_pipe_in", bus.pipe_in, 32'hDEAD_BEEF);
    step();
    bus.req_valid = '0;
    #1 dchk("single_out_c1", outstanding, 1);
    repeat (4) step();
    #1;
    dchk("single_rsp_valid_c5", bus.rsp_valid, 4'b0100);
    dchk("single_rsp_data_c5", bus.rsp_data, 32'hDEAD_BEEF);
    step();
    #1 dchk("single_out_c6", outstanding, 0);

    // One request from requester 3 so the next search starts at 0.
    step();
    bus.req_data[3*WIDTH +: WIDTH] = 32'h0BAD_F00D;
    bus.req_valid = 4'b1000;
    #1 dchk("req3_ready", bus.req_ready, 4'b1000);
    step();
    bus.req_valid = '0;
    repeat (6) step();

    // Fairness: everyone valid, responses accepted at once.
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 32'hA000_0000 + 32'(i);
    bus.req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      #1 dchk("fair_grant", bus.req_ready, fair_tbl[c]);
      step();
    end
    bus.req_valid = '0;
    repeat (10) step();

    // Credit exhaustion with no responses accepted.
    bus.rsp_ready = '0;
    bus.req_valid = '1;
    repeat (4) step();
    for (int c = 4; c < 14; c++) begin
      #1 dchk("credit_blocked", bus.req_ready, 0);
      step();
    end
    dchk("credit_out_full", outstanding, 4);
    bus.rsp_ready = '1;
    #1 dchk("credit_no_same_cycle", bus.req_ready, 0);
    step();
    bus.rsp_ready = '0;
    #1;
    dchk("credit_regrant", bus.req_ready, 4'b0001);
    dchk("credit_out_after_pop", outstanding, 3);
    step();
    #1;
    dchk("credit_refilled", bus.req_ready, 0);
    dchk("credit_out_refilled", outstanding, 4);

    // Simultaneous issue and pop at outstanding 3.
    bus.rsp_ready = '1;
    #1 dchk("sim_head_r1", bus.rsp_valid, 4'b0010);
    step();
    #1;
    dchk("sim_out_before", outstanding, 3);
    dchk("sim_grant", bus.req_ready, 4'b0010);
    dchk("sim_pop_head", bus.rsp_valid, 4'b0100);
    step();
    bus.req_valid = '0;
    #1 dchk("sim_out_after", outstanding, 3);
    repeat (12) step();

    // Head-of-line blocking: requester 1 ahead of requester 3.
    bus.rsp_ready = 4'b1000;
    bus.req_data[1*WIDTH +: WIDTH] = 32'h1111_1111;
    bus.req_data[3*WIDTH +: WIDTH] = 32'h3333_3333;
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b1000;
    step();
    bus.req_valid = '0;
    repeat (6) step();
    #1;
    dchk("hol_blocked_valid", bus.rsp_valid, 4'b0010);
    dchk("hol_blocked_data", bus.rsp_data, 32'h1111_1111);
    dchk("hol_blocked_out", outstanding, 2);
    bus.rsp_ready = 4'b1010;
    step();
    #1;
    dchk("hol_second_valid", bus.rsp_valid, 4'b1000);
    dchk("hol_second_data", bus.rsp_data, 32'h3333_3333);
    dchk("hol_second_out", outstanding, 1);
    step();
    #1 dchk("hol_drained", outstanding, 0);

    // Async reset with two entries in the FIFO and two in flight.
    bus.rsp_ready = '0;
    bus.req_valid = '1;
    repeat (2) step();
    bus.req_valid = '0;
    repeat (2) step();
    bus.req_valid = '1;
    repeat (2) step();
    bus.req_valid = '0;
    #1;
    dchk("arst_pre_head", bus.rsp_valid, 4'b0001);
    dchk("arst_pre_out", outstanding, 4);
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    #1 rst = 1'b0;
    #1;
    dchk("arst_req_ready", bus.req_ready, 0);
    dchk("arst_pipe_in_valid", bus.pipe_in_valid, 0);
    dchk("arst_pipe_in", bus.pipe_in, 0);
    dchk("arst_rsp_valid", bus.rsp_valid, 0);
    dchk("arst_rsp_data", bus.rsp_data, 0);
    dchk("arst_outstanding", outstanding, 0);
    step();
    bus.req_valid = '0;
    rst = 1'b1;
    for (int c = 0; c < 2*DEPTH; c++) begin
      #1;
      dchk("arst_no_rsp", bus.rsp_valid, 0);
      dchk("arst_out_zero", outstanding, 0);
      step();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", m_pass + s_pass + d_pass, m_tot + s_tot + d_tot);
    $finish;
  end
endmodule
